bus_grant_ctrl: RTL and testbench

BUS_GRANT_CTRL -- requirements
Module: bus_grant_ctrl

---
 rtl/bus_grant_ctrl.sv | 132 +++++++++++++
 tb/tb_bus_grant_ctrl.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/bus_grant_ctrl.sv
// Bus ownership arbiter for IFU reads, EXU loads and EXU stores on a shared bus.
// It adds IFU anti-starvation, release on R/B completion and a hold-time watchdog.
module bus_grant_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 1023,
    parameter int unsigned STARVE_LIMIT   = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic ifu_req_i,
    input  logic exu_rd_req_i,
    input  logic exu_wr_req_i,
    input  logic rvalid_i,
    input  logic rready_i,
    input  logic rlast_i,
    input  logic bvalid_i,
    input  logic bready_i,
    output logic gnt_ifu_o,
    output logic gnt_exu_rd_o,
    output logic gnt_exu_wr_o,
    output logic busy_o,
    output logic timeout_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWN_IFU = 2'd1,
        OWN_EXR = 2'd2,
        OWN_EXW = 2'd3
    } state_t;

    localparam logic [3:0]  STARVE_LIM_C = 4'(STARVE_LIMIT);
    localparam logic [15:0] HOLD_LAST_C  = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_r;
    state_t      state_nxt_s;
    logic [3:0]  streak_r;
    logic [3:0]  streak_nxt_s;
    logic [3:0]  streak_inc_s;
    logic [15:0] hold_r;
    logic [15:0] hold_nxt_s;
    logic        timeout_r;
    logic        timeout_nxt_s;
    logic        r_done_s;
    logic        b_done_s;
    logic        done_s;

    // Arbitration decision, completion detection and watchdog next-state logic.
    always_comb begin
        state_nxt_s   = state_r;
        streak_nxt_s  = streak_r;
        hold_nxt_s    = hold_r;
        timeout_nxt_s = 1'b0;
        done_s        = 1'b0;
        r_done_s      = rvalid_i & rready_i & rlast_i;
        b_done_s      = bvalid_i & bready_i;

        if (streak_r == 4'd15) begin
            streak_inc_s = 4'd15;
        end else begin
            streak_inc_s = streak_r + 4'd1;
        end

        case (state_r)
            IDLE: begin
                hold_nxt_s = 16'd0;
                // A starved IFU wins outright; otherwise stores, then loads, then fetches.
                if (ifu_req_i && (streak_r == STARVE_LIM_C)) begin
                    state_nxt_s  = OWN_IFU;
                    streak_nxt_s = 4'd0;
                end else if (exu_wr_req_i) begin
                    state_nxt_s  = OWN_EXW;
                    streak_nxt_s = ifu_req_i ? streak_inc_s : 4'd0;
                end else if (exu_rd_req_i) begin
                    state_nxt_s  = OWN_EXR;
                    streak_nxt_s = ifu_req_i ? streak_inc_s : 4'd0;
                end else if (ifu_req_i) begin
                    state_nxt_s  = OWN_IFU;
                    streak_nxt_s = 4'd0;
                end else begin
                    state_nxt_s  = IDLE;
                end
            end
            OWN_IFU, OWN_EXR: begin
                done_s = r_done_s;
            end
            OWN_EXW: begin
                done_s = b_done_s;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase

        // Completion takes precedence over an expiring watchdog in the same cycle.
        if (state_r != IDLE) begin
            if (done_s) begin
                state_nxt_s = IDLE;
                hold_nxt_s  = 16'd0;
            end else if (hold_r == HOLD_LAST_C) begin
                state_nxt_s   = IDLE;
                hold_nxt_s    = 16'd0;
                timeout_nxt_s = 1'b1;
            end else begin
                hold_nxt_s = hold_r + 16'd1;
            end
        end else begin
            done_s = 1'b0;
        end
    end

    // State, starvation streak, hold counter and timeout pulse registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r   <= IDLE;
            streak_r  <= 4'd0;
            hold_r    <= 16'd0;
            timeout_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            streak_r  <= streak_nxt_s;
            hold_r    <= hold_nxt_s;
            timeout_r <= timeout_nxt_s;
        end
    end

    assign gnt_ifu_o    = (state_r == OWN_IFU);
    assign gnt_exu_rd_o = (state_r == OWN_EXR);
    assign gnt_exu_wr_o = (state_r == OWN_EXW);
    assign busy_o       = (state_r != IDLE);
    assign timeout_o    = timeout_r;

endmodule

// File: tb/tb_bus_grant_ctrl.sv
// Scoreboard bench for bus_grant_ctrl: directed scenarios plus random traffic
// against a transaction-level ownership model.
module tb_bus_grant_ctrl;

    localparam int TO_C = 8;
    localparam int SL_C = 2;

    logic clock = 1'b0;
    logic reset;
    logic ifu_req_i, exu_rd_req_i, exu_wr_req_i;
    logic rvalid_i, rready_i, rlast_i, bvalid_i, bready_i;
    logic gnt_ifu_o, gnt_exu_rd_o, gnt_exu_wr_o, busy_o, timeout_o;

    int checks = 0;
    int errors = 0;
    logic [4:0] exp_q[$];

    // Reference model: who owns the bus, for how many cycles, how long IFU has waited.
    int m_owner  = 0;   // 0 none, 1 IFU, 2 EXU load, 3 EXU store
    int m_held   = 0;
    int m_streak = 0;
    bit m_to     = 1'b0;

    bus_grant_ctrl #(.TIMEOUT_CYCLES(TO_C), .STARVE_LIMIT(SL_C)) dut (
        .clock(clock), .reset(reset),
        .ifu_req_i(ifu_req_i), .exu_rd_req_i(exu_rd_req_i), .exu_wr_req_i(exu_wr_req_i),
        .rvalid_i(rvalid_i), .rready_i(rready_i), .rlast_i(rlast_i),
        .bvalid_i(bvalid_i), .bready_i(bready_i),
        .gnt_ifu_o(gnt_ifu_o), .gnt_exu_rd_o(gnt_exu_rd_o), .gnt_exu_wr_o(gnt_exu_wr_o),
        .busy_o(busy_o), .timeout_o(timeout_o)
    );

    always #5 clock = ~clock;

    function automatic logic [4:0] exp_vec();
        logic [4:0] e;
        e[4] = (m_owner == 1);
        e[3] = (m_owner == 2);
        e[2] = (m_owner == 3);
        e[1] = (m_owner != 0);
        e[0] = m_to;
        return e;
    endfunction

    // v = {reset, ifu, rd, wr, rvalid, rready, rlast, bvalid, bready}
    task automatic model_update(input logic [8:0] v);
        bit done;
        if (v[8]) begin
            m_owner = 0; m_streak = 0; m_held = 0; m_to = 1'b0;
        end else if (m_owner == 0) begin
            m_to = 1'b0;
            if (v[7] && m_streak == SL_C) begin
                m_owner = 1; m_streak = 0;
            end else if (v[6] || v[5]) begin
                m_owner  = v[5] ? 3 : 2;
                m_streak = v[7] ? ((m_streak < 15) ? m_streak + 1 : 15) : 0;
            end else if (v[7]) begin
                m_owner = 1; m_streak = 0;
            end
            m_held = (m_owner != 0) ? 1 : 0;
        end else begin
            done = (m_owner == 3) ? (v[1] && v[0]) : (v[4] && v[3] && v[2]);
            if (done) begin
                m_owner = 0; m_to = 1'b0;
            end else if (m_held == TO_C) begin
                m_owner = 0; m_to = 1'b1;
            end else begin
                m_held++; m_to = 1'b0;
            end
        end
    endtask

    task automatic step(input logic [8:0] v);
        @(negedge clock);
        {reset, ifu_req_i, exu_rd_req_i, exu_wr_req_i,
         rvalid_i, rready_i, rlast_i, bvalid_i, bready_i} = v;
        model_update(v);
        exp_q.push_back(exp_vec());
    endtask

    task automatic check_out(input logic [4:0] want, input string tag);
        logic [4:0] a;
        a = {gnt_ifu_o, gnt_exu_rd_o, gnt_exu_wr_o, busy_o, timeout_o};
        checks++;
        if (a !== want) begin
            errors++;
            $display("FAIL %s t=%0t {ifu,exr,exw,busy,timeout} got=%b want=%b",
                     tag, $time, a, want);
        end
    endtask

    // Monitor: compares every presented output cycle against the queued expectation.
    initial begin
        logic [4:0] e;
        logic [4:0] a;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {gnt_ifu_o, gnt_exu_rd_o, gnt_exu_wr_o, busy_o, timeout_o};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL outputs t=%0t {ifu,exr,exw,busy,timeout} got=%b want=%b",
                             $time, a, e);
                end
            end
        end
    end

    initial begin
        logic [8:0] v;
        {reset, ifu_req_i, exu_rd_req_i, exu_wr_req_i,
         rvalid_i, rready_i, rlast_i, bvalid_i, bready_i} = 9'b1_000_000_00;
        repeat (3) step(9'b1_000_000_00);
        check_out(5'b00000, "reset state");

        // IFU fetch, request dropped, released only by the last R beat
        step(9'b0_100_000_00);
        step(9'b0_000_110_00);
        repeat (2) step(9'b0_000_000_00);
        step(9'b0_000_111_00);
        repeat (2) step(9'b0_000_000_00);

        // All requesters: store first, R and partial B ignored, B handshake releases
        step(9'b0_111_000_00);
        step(9'b0_000_111_00);
        step(9'b0_000_000_10);
        step(9'b0_000_000_01);
        step(9'b0_000_000_11);
        step(9'b0_000_000_00);

        // Starvation: EXR, EXR, IFU, ... with single-cycle completions
        repeat (2) step(9'b1_000_000_00);
        repeat (14) step(9'b0_110_111_00);

        // Watchdog expiry, then completion on the final allowed cycle
        repeat (2) step(9'b1_000_000_00);
        step(9'b0_010_000_00);
        repeat (9) step(9'b0_000_000_00);
        check_out(5'b00001, "expired wait");
        step(9'b0_000_000_00);
        step(9'b0_010_000_00);
        repeat (7) step(9'b0_000_000_00);
        step(9'b0_000_111_00);
        repeat (2) step(9'b0_000_000_00);

        // Reset dominating a B completion mid-store, then a normal grant
        step(9'b0_101_000_00);
        step(9'b0_000_000_00);
        step(9'b1_000_000_11);
        step(9'b0_100_000_00);
        step(9'b0_000_000_00);
        step(9'b0_000_111_00);
        step(9'b0_000_000_00);

        // Random traffic
        repeat (3000) begin
            v[8] = ($urandom_range(0, 99) == 0);
            v[7] = $urandom_range(0, 1) == 1;
            v[6] = $urandom_range(0, 2) == 0;
            v[5] = $urandom_range(0, 3) == 0;
            v[4] = $urandom_range(0, 1) == 1;
            v[3] = $urandom_range(0, 9) < 7;
            v[2] = $urandom_range(0, 2) == 0;
            v[1] = $urandom_range(0, 9) < 3;
            v[0] = $urandom_range(0, 9) < 7;
            step(v);
        end
        repeat (2) step(9'b0_000_000_00);

        @(posedge clock);
        #3;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
